// File: rtl/inst_fetcher_pkg.sv
// Shared constants, queue entry layout and next-PC prediction for the instruction fetcher.
// All fetch-side modules import this package so the JAL opcode and default depth exist once.
package inst_fetcher_pkg;

  localparam int          IQ_DEPTH_DEFAULT = 4;
  localparam logic [6:0]  OPC_JAL          = 7'b1101111;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pred;
  } iq_entry_t;

  // Static prediction: only JAL is taken, everything else falls through.
  function automatic logic [31:0] predict_next_pc(input logic [31:0] pc_v, input logic [31:0] inst_v);
    logic [31:0] imm_v;
    imm_v = {{11{inst_v[31]}}, inst_v[31], inst_v[19:12], inst_v[20], inst_v[30:21], 1'b0};
    if (inst_v[6:0] == OPC_JAL) begin
      return pc_v + imm_v;
    end else begin
      return pc_v + 32'd4;
    end
  endfunction

endpackage

// File: rtl/inst_queue.sv
// Circular instruction FIFO between fetch and decode.
// en freezes every register; clear empties the queue and beats any same-cycle push/pop.
module inst_queue
  import inst_fetcher_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      en,
  input  logic      clear,
  input  logic      push,
  input  iq_entry_t push_data,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output iq_entry_t head_data
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  iq_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Occupancy flags and qualified push/pop strobes.
  always_comb begin
    full_s    = (count_r == FULL_CNT);
    empty_s   = (count_r == '0);
    push_ok_s = push && !full_s;
    pop_ok_s  = pop && !empty_s;
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (en && clear) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (en) begin
      if (push_ok_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end else begin
      head_r  <= head_r;
      tail_r  <= tail_r;
      count_r <= count_r;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_in) begin
    if (rst_in && en && !clear && push_ok_s) begin
      mem_r[tail_r] <= push_data;
    end
  end

  assign full      = full_s;
  assign empty     = empty_s;
  assign head_data = mem_r[head_r];

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch front end: owns fetch_pc, predicts the next PC and
// buffers returned words in an instruction queue for the decoder.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int IQ_DEPTH = IQ_DEPTH_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear_up,
  input  logic [31:0] rob_new_pc,
  output logic [31:0] pc,
  output logic        should_fetch,
  input  logic        fetch_ready,
  input  logic [31:0] inst,
  input  logic [31:0] inst_addr,
  output logic        iq_valid,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  output logic [31:0] iq_pred_pc,
  input  logic        iq_pop
);

  logic [31:0] fetch_pc_r;
  logic [31:0] pred_s;
  logic        accept_s;
  logic        full_s;
  logic        empty_s;
  iq_entry_t   push_data_s;
  iq_entry_t   head_s;

  // A response counts only if it answers the current request and there is room for it.
  always_comb begin
    pred_s      = predict_next_pc(fetch_pc_r, inst);
    accept_s    = fetch_ready && (inst_addr == fetch_pc_r) && !rob_clear_up && !full_s;
    push_data_s = '{inst: inst, pc: fetch_pc_r, pred: pred_s};
  end

  // Fetch address: redirect beats sequential advance; rdy_in low freezes it.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      fetch_pc_r <= 32'd0;
    end else if (rdy_in && rob_clear_up) begin
      fetch_pc_r <= rob_new_pc;
    end else if (rdy_in && accept_s) begin
      fetch_pc_r <= pred_s;
    end else begin
      fetch_pc_r <= fetch_pc_r;
    end
  end

  inst_queue #(
    .DEPTH (IQ_DEPTH)
  ) u_inst_queue (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en        (rdy_in),
    .clear     (rob_clear_up),
    .push      (accept_s),
    .push_data (push_data_s),
    .pop       (iq_pop),
    .full      (full_s),
    .empty     (empty_s),
    .head_data (head_s)
  );

  assign pc           = fetch_pc_r;
  assign should_fetch = !full_s;
  assign iq_valid     = !empty_s;
  assign iq_inst      = head_s.inst;
  assign iq_pc        = head_s.pc;
  assign iq_pred_pc   = head_s.pred;

endmodule
